mc_controller: RTL and testbench

- Control unit for the multicycle RV32I subset (lw, sw, R-type, I-type ALU, beq, jal).
- Sequences the shared ALU, memory, register file and PC/IR datapath through a Moore main state machine.
- Derives ALUControl from ALUOp, funct3, funct7b5 and op[5].
- Sits between the instruction register and the multicycle datapath; replaces the single-cycle controller.

---
 rtl/mc_pkg.sv | 58 +++++
 rtl/mc_mainfsm.sv | 129 ++++++++++++
 rtl/mc_controller.sv | 78 +++++++
 tb/tb_mc_controller.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// mc_pkg: shared state, opcode and mux encodings
// for the multicycle RV32I control unit.
package mc_pkg;
    localparam int STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_BEQ,
        S_JAL
    } statetype_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_SUB = 2'b01;
    localparam logic [1:0] ALUOP_FN  = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    function automatic logic op_legal(input logic [6:0] op);
        return op inside {OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL};
    endfunction
endpackage

// File: rtl/mc_mainfsm.sv
// mc_mainfsm: Moore main state machine sequencing
// the multicycle datapath.
module mc_mainfsm
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       Branch,
    output logic       PCUpdate,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp
);
    statetype_t state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            unique case (state)
                S_FETCH: state <= S_DECODE;
                S_DECODE: begin
                    unique case (1'b1)
                        op == OP_LW,
                        op == OP_SW:  state <= S_MEMADR;
                        op == OP_R:   state <= S_EXECUTER;
                        op == OP_I:   state <= S_EXECUTEI;
                        op == OP_JAL: state <= S_JAL;
                        op == OP_BEQ: state <= S_BEQ;
                        default:      state <= S_FETCH;
                    endcase
                end
                S_MEMADR:
                    state <= (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
                S_MEMREAD: state <= S_MEMWB;
                S_EXECUTER,
                S_EXECUTEI,
                S_JAL: state <= S_ALUWB;
                default: state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        Branch     = 1'b0;
        PCUpdate   = 1'b0;
        instr_done = 1'b0;
        illegal_op = 1'b0;
        ResultSrc  = RES_ALUOUT;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_RD2;
        ALUOp      = ALUOP_ADD;
        unique case (state)
            S_FETCH: begin
                IRWrite   = 1'b1;
                PCUpdate  = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURES;
            end
            S_DECODE: begin
                ALUSrcA    = SRCA_OLDPC;
                ALUSrcB    = SRCB_IMM;
                illegal_op = !op_legal(op);
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD: AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc  = RES_DATA;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc     = 1'b1;
                MemWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_EXECUTER: begin
                ALUSrcA = SRCA_RD1;
                ALUOp   = ALUOP_FN;
            end
            S_EXECUTEI: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
                ALUOp   = ALUOP_FN;
            end
            S_JAL: begin
                ALUSrcA  = SRCA_OLDPC;
                ALUSrcB  = SRCB_FOUR;
                PCUpdate = 1'b1;
            end
            S_ALUWB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA    = SRCA_RD1;
                ALUOp      = ALUOP_SUB;
                Branch     = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase
        // Reset aborts any in-flight instruction without side effects.
        if (reset) begin
            MemWrite   = 1'b0;
            IRWrite    = 1'b0;
            RegWrite   = 1'b0;
            Branch     = 1'b0;
            PCUpdate   = 1'b0;
            instr_done = 1'b0;
            illegal_op = 1'b0;
        end
    end
endmodule

// File: rtl/mc_controller.sv
// mc_controller: multicycle RV32I control unit --
// main FSM plus ALU decode, immediate select and PC enable.
module mc_controller
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic       RegWrite,
    output logic [2:0] ALUControl,
    output logic       instr_done,
    output logic       illegal_op
);
    logic [1:0] ALUOp;
    logic       Branch;
    logic       PCUpdate;

    mc_mainfsm u_fsm (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .Branch     (Branch),
        .PCUpdate   (PCUpdate),
        .instr_done (instr_done),
        .illegal_op (illegal_op),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUOp      (ALUOp)
    );

    assign PCWrite = PCUpdate | (Branch & Zero);

    always_comb begin
        ALUControl = ALU_ADD;
        case (ALUOp)
            ALUOP_SUB: ALUControl = ALU_SUB;
            ALUOP_FN: begin
                case (funct3)
                    // op[5] separates sub from addi with imm[10] set
                    3'b000: ALUControl = (funct7b5 & op[5]) ?
                                         ALU_SUB : ALU_ADD;
                    3'b010: ALUControl = ALU_SLT;
                    3'b100: ALUControl = ALU_XOR;
                    3'b110: ALUControl = ALU_OR;
                    3'b111: ALUControl = ALU_AND;
                    default: ALUControl = ALU_ADD;
                endcase
            end
            default: ALUControl = ALU_ADD;
        endcase
    end

    always_comb begin
        ImmSrc = IMM_I;
        case (op)
            OP_SW:   ImmSrc = IMM_S;
            OP_BEQ:  ImmSrc = IMM_B;
            OP_JAL:  ImmSrc = IMM_J;
            default: ImmSrc = IMM_I;
        endcase
    end
endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: scenario tasks plus random instruction
// streams checked against a per-instruction step model.
module tb_mc_controller;
    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic       instr_done, illegal_op;

    int n_checks = 0;
    int n_fail = 0;

    mc_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .Zero       (Zero),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .RegWrite   (RegWrite),
        .ALUControl (ALUControl),
        .instr_done (instr_done),
        .illegal_op (illegal_op)
    );

    always #5 clk = ~clk;

    typedef enum int {
        SF, SD, SMA, SMR, SMW, SMWR, SXR, SXI, SJ, SWB, SB, SRST
    } step_t;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BEQ = 7'b1100011;
    localparam logic [6:0] JAL = 7'b1101111;

    function automatic int lat(input logic [6:0] o);
        case (o)
            LW:              return 5;
            SW, RT, IT, JAL: return 4;
            BEQ:             return 3;
            default:         return 2;
        endcase
    endfunction

    function automatic step_t step_of(input logic [6:0] o, input int c);
        if (c == 0) return SF;
        if (c == 1) return SD;
        case (o)
            LW:  return (c == 2) ? SMA : (c == 3) ? SMR : SMW;
            SW:  return (c == 2) ? SMA : SMWR;
            RT:  return (c == 2) ? SXR : SWB;
            IT:  return (c == 2) ? SXI : SWB;
            JAL: return (c == 2) ? SJ : SWB;
            BEQ: return SB;
            default: return SD;
        endcase
    endfunction

    function automatic logic [2:0] alu_fn(input logic [2:0] f3,
                                          input logic f7,
                                          input logic [6:0] o);
        case (f3)
            3'b000:  return (f7 && o[5]) ? 3'd1 : 3'd0;
            3'b010:  return 3'd5;
            3'b100:  return 3'd4;
            3'b110:  return 3'd3;
            3'b111:  return 3'd2;
            default: return 3'd0;
        endcase
    endfunction

    // {pcw,adr,mw,irw,rs,sa,sb,imm,rw,alu,done,ill}
    function automatic logic [17:0] exp_of(input step_t s,
                                           input logic [6:0] o,
                                           input logic [2:0] f3,
                                           input logic f7,
                                           input logic z);
        logic pcw, adr, mw, irw, rw, done, ill;
        logic [1:0] rs, sa, sb, imm;
        logic [2:0] alu;
        int aop;
        pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0; done = 0; ill = 0;
        rs = 0; sa = 0; sb = 0; aop = 0;
        case (s)
            SF:   begin irw = 1; pcw = 1; sb = 2; rs = 2; end
            SD:   begin sa = 1; sb = 1; ill = (lat(o) == 2); end
            SMA:  begin sa = 2; sb = 1; end
            SMR:  adr = 1;
            SMW:  begin rs = 1; rw = 1; done = 1; end
            SMWR: begin adr = 1; mw = 1; done = 1; end
            SXR:  begin sa = 2; aop = 2; end
            SXI:  begin sa = 2; sb = 1; aop = 2; end
            SJ:   begin sa = 1; sb = 2; pcw = 1; end
            SWB:  begin rw = 1; done = 1; end
            SB:   begin sa = 2; aop = 1; pcw = z; done = 1; end
            SRST: begin sb = 2; rs = 2; end
            default: ;
        endcase
        alu = (aop == 0) ? 3'd0 : (aop == 1) ? 3'd1 : alu_fn(f3, f7, o);
        case (o)
            SW:      imm = 2'b01;
            BEQ:     imm = 2'b10;
            JAL:     imm = 2'b11;
            default: imm = 2'b00;
        endcase
        return {pcw, adr, mw, irw, rs, sa, sb, imm, rw, alu, done, ill};
    endfunction

    // Drive Zero, sample at the falling edge, step past the next rising edge.
    task automatic cycle(input logic z, output logic [17:0] got);
        Zero = z;
        @(negedge clk);
        got = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
               ALUSrcB, ImmSrc, RegWrite, ALUControl, instr_done,
               illegal_op};
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [17:0] got, want;
        logic z;
        int done_cnt = 0;
        reset = 1; op = LW; funct3 = 0; funct7b5 = 0; Zero = 0;
        #1;
        for (int c = 0; c < 3; c++) begin
            cycle(1'b1, got);
            want = exp_of(SRST, op, funct3, funct7b5, 1'b1);
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL reset c%0d got %b want %b", c, got, want);
            end
        end
        reset = 0;
        for (int c = 0; c < lat(op); c++) begin
            z = 1'($urandom_range(0, 1));
            cycle(z, got);
            want = exp_of(step_of(op, c), op, funct3, funct7b5, z);
            done_cnt += int'(got[1]);
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL lw c%0d got %b want %b", c, got, want);
            end
        end
        n_checks++;
        if (done_cnt != 1) begin
            n_fail++;
            $display("FAIL lw_done_count got %0d want 1", done_cnt);
        end
    endtask

    task automatic test_alu_decode();
        logic [6:0] ops[3] = '{RT, RT, IT};
        logic f7s[3] = '{1'b1, 1'b0, 1'b1};
        logic [2:0] alus[3] = '{3'b001, 3'b000, 3'b000};
        logic [17:0] got, want;
        for (int k = 0; k < 3; k++) begin
            op = ops[k]; funct3 = 3'b000; funct7b5 = f7s[k];
            for (int c = 0; c < lat(op); c++) begin
                cycle(1'b0, got);
                want = exp_of(step_of(op, c), op, funct3, funct7b5, 1'b0);
                n_checks++;
                if (got !== want) begin
                    n_fail++;
                    $display("FAIL alu%0d c%0d got %b want %b",
                             k, c, got, want);
                end
                if (c == 2) begin
                    n_checks++;
                    if (got[4:2] !== alus[k]) begin
                        n_fail++;
                        $display("FAIL aluctl%0d got %b want %b",
                                 k, got[4:2], alus[k]);
                    end
                end
            end
        end
    endtask

    task automatic test_beq();
        logic [17:0] got, want;
        int pcw_cnt;
        for (int z = 1; z >= 0; z--) begin
            op = BEQ; funct3 = 0; funct7b5 = 0;
            pcw_cnt = 0;
            for (int c = 0; c < lat(op); c++) begin
                cycle(1'(z), got);
                want = exp_of(step_of(op, c), op, funct3, funct7b5, 1'(z));
                pcw_cnt += int'(got[17]);
                n_checks++;
                if (got !== want) begin
                    n_fail++;
                    $display("FAIL beq z%0d c%0d got %b want %b",
                             z, c, got, want);
                end
            end
            n_checks++;
            if (pcw_cnt != 1 + z) begin
                n_fail++;
                $display("FAIL beq_pcw z%0d got %0d want %0d",
                         z, pcw_cnt, 1 + z);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] ops[2] = '{SW, JAL};
        logic [17:0] got, want;
        for (int k = 0; k < 2; k++) begin
            op = ops[k]; funct3 = 3'($urandom); funct7b5 = 1'($urandom);
            for (int c = 0; c < lat(op); c++) begin
                cycle(1'b0, got);
                want = exp_of(step_of(op, c), op, funct3, funct7b5, 1'b0);
                n_checks++;
                if (got !== want) begin
                    n_fail++;
                    $display("FAIL b2b%0d c%0d got %b want %b",
                             k, c, got, want);
                end
                if (k == 0) begin
                    n_checks++;
                    if (got[15] !== (c == 3)) begin
                        n_fail++;
                        $display("FAIL sw_memwrite c%0d got %b", c, got[15]);
                    end
                end
                if (k == 1 && c == 2) begin
                    n_checks++;
                    if ({got[17], got[11:8]} !== 5'b1_01_10) begin
                        n_fail++;
                        $display("FAIL jal_state got %b want 10110",
                                 {got[17], got[11:8]});
                    end
                end
            end
        end
    endtask

    task automatic test_illegal();
        logic [17:0] got, want;
        op = 7'b1111111; funct3 = 0; funct7b5 = 0;
        for (int c = 0; c < lat(op); c++) begin
            cycle(1'b1, got);
            want = exp_of(step_of(op, c), op, funct3, funct7b5, 1'b1);
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL illegal c%0d got %b want %b", c, got, want);
            end
        end
        op = IT;
        cycle(1'b0, got);
        n_checks++;
        if (got[14] !== 1'b1) begin
            n_fail++;
            $display("FAIL illegal_next got irw %b want 1", got[14]);
        end
        // finish the addi so the next task starts at an instruction boundary
        for (int c = 1; c < lat(op); c++) cycle(1'b0, got);
    endtask

    task automatic test_reset_mid();
        logic [17:0] got, want;
        op = LW; funct3 = 0; funct7b5 = 0;
        for (int c = 0; c < 3; c++) begin
            cycle(1'b0, got);
            want = exp_of(step_of(op, c), op, funct3, funct7b5, 1'b0);
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL rmid c%0d got %b want %b", c, got, want);
            end
        end
        reset = 1;
        for (int c = 0; c < 2; c++) begin
            cycle(1'b1, got);
            want = exp_of(SRST, op, funct3, funct7b5, 1'b1);
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL rmid_hold c%0d got %b want %b", c, got, want);
            end
        end
        reset = 0;
        for (int c = 0; c < lat(op); c++) begin
            cycle(1'b0, got);
            want = exp_of(step_of(op, c), op, funct3, funct7b5, 1'b0);
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL rmid_after c%0d got %b want %b", c, got, want);
            end
        end
    endtask

    task automatic test_random();
        logic [6:0] set[6] = '{LW, SW, RT, IT, BEQ, JAL};
        logic [17:0] got, want;
        logic z;
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 7) == 0) op = 7'($urandom);
            else op = set[$urandom_range(0, 5)];
            funct3 = 3'($urandom);
            funct7b5 = 1'($urandom);
            for (int c = 0; c < lat(op); c++) begin
                z = 1'($urandom);
                cycle(z, got);
                want = exp_of(step_of(op, c), op, funct3, funct7b5, z);
                n_checks++;
                if (got !== want) begin
                    n_fail++;
                    $display("FAIL rand%0d op %b c%0d got %b want %b",
                             n, op, c, got, want);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_alu_decode();
        test_beq();
        test_back_to_back();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
